dac_spi_arbiter: RTL

//  Shares the single 24-bit DAC SPI serializer between two requesters: the audio sample path
//  (stereo pair, channel A then channel B, never split) and a config path (single command word).

---
 rtl/dac_spi_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter
// Shares one 24-bit DAC SPI serializer between the audio sample path (stereo
// pair A then B, never split) and the config path (single command word).
// Cfg is preferred unless audio is also pending, but audio cannot lock cfg out:
// after STARVE_LIMIT consecutive audio grants with cfg waiting, cfg goes next.
// A watchdog aborts any word that stays in SEND/WAIT for TIMEOUT_CYCLES cycles.
// All outputs come straight from registers.

module dac_spi_arbiter #(
    parameter logic [2:0]  STARVE_LIMIT   = 3'd4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2048
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Audio_Req,
    input  logic [23:0] i_Audio_Data_A,
    input  logic [23:0] i_Audio_Data_B,
    output logic        o_Audio_Ack,
    input  logic        i_Cfg_Req,
    input  logic [23:0] i_Cfg_Data,
    output logic        o_Cfg_Ack,
    output logic [23:0] o_DAC_Data,
    output logic        o_DAC_Send,
    input  logic        i_DAC_Ready,
    output logic        o_Busy,
    output logic        o_Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    typedef enum logic {
        OWN_AUDIO,
        OWN_CFG
    } owner_t;

    state_t      state_q,    state_n;
    owner_t      owner_q,    owner_n;
    logic        word_idx_q, word_idx_n;
    logic [23:0] hold_b_q,   hold_b_n;
    logic [2:0]  starve_q,   starve_n;
    logic [15:0] wdog_q,     wdog_n;
    logic [23:0] data_q,     data_n;
    logic        send_q,     send_n;
    logic        aack_q,     aack_n;
    logic        cack_q,     cack_n;
    logic        busy_q,     busy_n;
    logic        tmo_q,      tmo_n;
    logic        cfg_wins;

    // State and registered outputs; reset drops any transfer in flight.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_AUDIO;
            word_idx_q <= 1'b0;
            hold_b_q   <= '0;
            starve_q   <= '0;
            wdog_q     <= '0;
            data_q     <= '0;
            send_q     <= 1'b0;
            aack_q     <= 1'b0;
            cack_q     <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            owner_q    <= owner_n;
            word_idx_q <= word_idx_n;
            hold_b_q   <= hold_b_n;
            starve_q   <= starve_n;
            wdog_q     <= wdog_n;
            data_q     <= data_n;
            send_q     <= send_n;
            aack_q     <= aack_n;
            cack_q     <= cack_n;
            busy_q     <= busy_n;
            tmo_q      <= tmo_n;
        end
    end

    // Arbitration, serializer handshake, starvation count and watchdog.
    always_comb begin
        state_n    = state_q;
        owner_n    = owner_q;
        word_idx_n = word_idx_q;
        hold_b_n   = hold_b_q;
        starve_n   = starve_q;
        wdog_n     = wdog_q;
        data_n     = data_q;
        send_n     = send_q;
        aack_n     = 1'b0;
        cack_n     = 1'b0;
        tmo_n      = 1'b0;

        cfg_wins = i_Cfg_Req & (~i_Audio_Req | (starve_q >= STARVE_LIMIT));

        case (state_q)
            ST_IDLE: begin
                if (i_DAC_Ready && (i_Audio_Req || i_Cfg_Req)) begin
                    word_idx_n = 1'b0;
                    wdog_n     = '0;
                    send_n     = 1'b1;
                    state_n    = ST_SEND;
                    if (cfg_wins) begin
                        owner_n  = OWN_CFG;
                        data_n   = i_Cfg_Data;
                        starve_n = '0;
                    end else begin
                        owner_n  = OWN_AUDIO;
                        data_n   = i_Audio_Data_A;
                        hold_b_n = i_Audio_Data_B;
                        if (!i_Cfg_Req)
                            starve_n = '0;
                        else if (starve_q != '1)
                            starve_n = starve_q + 3'd1;
                    end
                end
            end

            ST_SEND, ST_WAIT: begin
                if (wdog_q == TIMEOUT_CYCLES - 16'd1) begin
                    // Abort takes precedence over any handshake in the same cycle.
                    send_n  = 1'b0;
                    tmo_n   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    wdog_n = wdog_q + 16'd1;
                    if (state_q == ST_SEND) begin
                        if (!i_DAC_Ready) begin
                            send_n  = 1'b0;
                            state_n = ST_WAIT;
                        end
                    end else if (i_DAC_Ready) begin
                        if (owner_q == OWN_AUDIO && !word_idx_q) begin
                            // Word B goes out directly so cfg cannot split the pair.
                            word_idx_n = 1'b1;
                            data_n     = hold_b_q;
                            wdog_n     = '0;
                            send_n     = 1'b1;
                            state_n    = ST_SEND;
                        end else begin
                            aack_n  = (owner_q == OWN_AUDIO);
                            cack_n  = (owner_q == OWN_CFG);
                            state_n = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                send_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    assign o_DAC_Data  = data_q;
    assign o_DAC_Send  = send_q;
    assign o_Audio_Ack = aack_q;
    assign o_Cfg_Ack   = cack_q;
    assign o_Busy      = busy_q;
    assign o_Timeout   = tmo_q;

endmodule
